// File: rtl/conv_border_crop.sv
// conv_border_crop: removes the invalid border words produced by the
// 8-pixel-parallel convolution stencil. The first CROP_TOP rows of each frame
// and the first CROP_LEFT_WORDS words of every remaining row are discarded.
// Surviving words pass through a 2-entry FIFO to the host interface. dout_last
// marks the final kept word of each frame.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds its data stable while valid is high and ready is
// low. din_ready comes from registers (and rst) only.
//
// Optional feature macro: CROP_STATS_EN adds the frame_count and drop_count
// outputs.
`timescale 1ns/1ps
module conv_border_crop #(
    parameter int IMG_W_WORDS     = 80,
    parameter int IMG_H           = 480,
    parameter int CROP_TOP        = 2,
    parameter int CROP_LEFT_WORDS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [63:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_last,
    output logic        dbg_state
`ifdef CROP_STATS_EN
    ,
    output logic [15:0] frame_count,
    output logic [31:0] drop_count
`endif
);
    localparam int CW = $clog2(IMG_W_WORDS);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W_WORDS - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
    localparam logic [RW-1:0] TOP_LAST = RW'((CROP_TOP == 0) ? 0 : CROP_TOP - 1);

    typedef enum logic {ST_TOP = 1'b0, ST_BODY = 1'b1} state_t;
    localparam state_t ST_INIT = (CROP_TOP == 0) ? ST_BODY : ST_TOP;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]    occ_q, occ_d;
    logic [63:0]   d0_q, d0_d, d1_q, d1_d;
    logic          l0_q, l0_d, l1_q, l1_d;

    logic accept, col_wrap, frame_wrap, keep, last_in, pop;

    // Handshake, frame position and crop decision.
    always_comb begin
        din_ready  = !rst && (occ_q != 2'd2);
        accept     = din_valid && din_ready;
        col_wrap   = (col_q == COL_MAX);
        frame_wrap = accept && col_wrap && (row_q == ROW_MAX);
        last_in    = col_wrap && (row_q == ROW_MAX);
        keep       = accept && (state_q == ST_BODY) && (int'(col_q) >= CROP_LEFT_WORDS);
        pop        = dout_valid && dout_ready;
        col_d      = col_q;
        row_d      = row_q;
        state_d    = state_q;
        if (accept) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
        case (state_q)
            ST_TOP:  if (accept && col_wrap && (row_q == TOP_LAST)) state_d = ST_BODY;
            ST_BODY: if (frame_wrap) state_d = ST_INIT;
            default: state_d = ST_INIT;
        endcase
    end

    // Two-entry output FIFO; entry 0 is always the head shown on dout.
    always_comb begin
        d0_d = d0_q;
        d1_d = d1_q;
        l0_d = l0_q;
        l1_d = l1_q;
        if (pop && (occ_q == 2'd2)) begin
            d0_d = d1_q;
            l0_d = l1_q;
        end
        if (keep) begin
            // The new word becomes head when the FIFO is, or is about to be, empty.
            if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)) begin
                d0_d = din;
                l0_d = last_in;
            end else begin
                d1_d = din;
                l1_d = last_in;
            end
        end
        occ_d = occ_q + {1'b0, keep} - {1'b0, pop};
    end

    assign dout       = d0_q;
    assign dout_valid = (occ_q != 2'd0);
    assign dout_last  = l0_q && dout_valid;
    assign dbg_state  = state_q;

`ifdef CROP_STATS_EN
    logic [15:0] frame_count_q, frame_count_d;
    logic [31:0] drop_count_q, drop_count_d;

    // Frames delivered to the host and words dropped in the current frame.
    always_comb begin
        frame_count_d = frame_count_q + {15'd0, pop && dout_last};
        drop_count_d  = drop_count_q;
        if (frame_wrap)
            drop_count_d = '0;
        else if (accept && !keep && (drop_count_q != '1))
            drop_count_d = drop_count_q + 32'd1;
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;
`endif

    // State, position and FIFO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            col_q   <= '0;
            row_q   <= '0;
            occ_q   <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
            l0_q    <= 1'b0;
            l1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            occ_q   <= occ_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            l0_q    <= l0_d;
            l1_q    <= l1_d;
        end
    end
endmodule

// File: tb/tb_conv_border_crop.sv
// Testbench for conv_border_crop on a 4-word x 3-row frame, with 1 top row
// and 1 left word cropped.
`timescale 1ns/1ps
module tb_conv_border_crop;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int CT = 1;
  localparam int CL = 1;
  localparam int FW = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [63:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        dout_last;
  logic        dbg_state;
`ifdef CROP_STATS_EN
  logic [15:0] frame_count;
  logic [31:0] drop_count;
`endif

  conv_border_crop #(
    .IMG_W_WORDS(W), .IMG_H(H), .CROP_TOP(CT), .CROP_LEFT_WORDS(CL)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .dbg_state(dbg_state)
`ifdef CROP_STATS_EN
    , .frame_count(frame_count), .drop_count(drop_count)
`endif
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ready_mode = 0;  // 0 low, 1 high, 2 random
  bit chk_lat  = 1'b0;

  logic [64:0] exp_q[$];  // {last, data}
  int          acc_q[$];  // cycle stamp at acceptance

  typedef struct {
    logic [63:0] din;
    logic        keep;
    logic        last;
  } vec_t;
  vec_t vec[FW];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0: dout_ready = 1'b0;
      1: dout_ready = 1'b1;
      default: dout_ready = 1'($urandom_range(1));
    endcase
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: condition not met at %0t", name, $time);
  endtask

  // Reference crop rule, from the word's position within the frame.
  function automatic logic [1:0] model(input int pos);
    int r;
    int c;
    r = pos / W;
    c = pos % W;
    return {(r >= CT) && (c >= CL), pos == FW - 1};
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [64:0] e;
    int          a;
    logic [63:0] prev_dout = '0;
    logic        prev_last = 1'b0;
    bit          prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 64'(dout_valid), 64'd1);
          check("hold_data", dout, prev_dout);
          check("hold_last", 64'(dout_last), 64'(prev_last));
        end
        if (!dout_valid) check("last_idle", 64'(dout_last), 64'd0);
        if (dout_valid && dout_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_output");
          end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("dout", dout, e[63:0]);
            check("dout_last", 64'(dout_last), 64'(e[64]));
            if (chk_lat) check("latency", 64'(cyc - a), 64'd1);
          end
        end
        prev_stall = dout_valid && !dout_ready;
        prev_dout  = dout;
        prev_last  = dout_last;
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send_word(input logic [63:0] w, input logic kp, input logic lst);
    int waited = 0;
    bit done = 1'b0;
    din = w;
    din_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (din_ready) begin
        if (kp) begin
          exp_q.push_back({lst, w});
          acc_q.push_back(cyc);
        end
        done = 1'b1;
      end else if (waited >= 300) begin
        fail_now("din_ready_timeout");
        done = 1'b1;
      end
      waited++;
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_dout_valid", 64'(dout_valid), 64'd0);
      check("rst_din_ready", 64'(din_ready), 64'd0);
      check("rst_dout_last", 64'(dout_last), 64'd0);
    end
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_dout", dout, 64'd0);
    check("post_rst_din_ready", 64'(din_ready), 64'd1);
    check("post_rst_state_top", 64'(dbg_state), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("drain_valid", 64'(dout_valid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_table();
    for (int i = 0; i < FW; i++) begin
      send_word(vec[i].din, vec[i].keep, vec[i].last);
      if (i == 2)  check("state_top_row0", 64'(dbg_state), 64'd0);
      if (i == 3)  check("state_body", 64'(dbg_state), 64'd1);
      if (i == 11) check("state_top_wrap", 64'(dbg_state), 64'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] m;
    for (int i = 0; i < FW; i++) begin
      vec[i].din  = 64'(i);
      vec[i].keep = (i == 5) || (i == 6) || (i == 7) || (i == 9) || (i == 10) || (i == 11);
      vec[i].last = (i == 11);
    end

    #1;
    do_reset();

    // 1: one frame, consumer always ready, 1-cycle latency.
    ready_mode = 1;
    chk_lat = 1'b1;
    idle(1);
    send_table();
    drain();

    // 2: consumer stalled; the FIFO fills after two kept words and holds its head.
    chk_lat = 1'b0;
    ready_mode = 0;
    idle(1);
    fork
      begin
        for (int i = 0; i < FW; i++) begin
          m = model(i);
          send_word(64'(i), m[1], m[0]);
        end
      end
      begin
        repeat (20) @(negedge clk);
        check("full_din_ready", 64'(din_ready), 64'd0);
        check("full_dout_valid", 64'(dout_valid), 64'd1);
        check("full_head", dout, 64'd5);
        repeat (3) begin
          @(negedge clk);
          check("full_head_hold", dout, 64'd5);
        end
        @(posedge clk);
        #1;
        ready_mode = 1;
      end
    join
    drain();

    // 4: reset mid-frame after word 6, then a clean frame.
    chk_lat = 1'b1;
    for (int i = 0; i <= 6; i++) send_word(vec[i].din, vec[i].keep, vec[i].last);
    do_reset();
    send_table();
    drain();
    chk_lat = 1'b0;

    // 3: two back-to-back frames (plus statistics when enabled).
    do_reset();
    for (int i = 0; i < 2 * FW; i++) begin
      m = model(i % FW);
      send_word(64'(i), m[1], m[0]);
`ifdef CROP_STATS_EN
      if (i % FW == FW - 2) check("drop_count_pre_wrap", 64'(drop_count), 64'd6);
      if (i % FW == FW - 1) check("drop_count_cleared", 64'(drop_count), 64'd0);
`endif
    end
    drain();
`ifdef CROP_STATS_EN
    check("frame_count_2", 64'(frame_count), 64'd2);
`endif

    // 5: random valid/ready over many frames against the reference rule.
    ready_mode = 2;
    for (int f = 0; f < 1000; f++) begin
      for (int p = 0; p < FW; p++) begin
        while ($urandom_range(1) == 1) idle(1);
        m = model(p);
        send_word({$urandom, $urandom}, m[1], m[0]);
      end
    end
    drain();
`ifdef CROP_STATS_EN
    check("frame_count_1002", 64'(frame_count), 64'd1002);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
